// File: rtl/ca_pkg.sv
// Shared constants and the runner state encoding for the cellular automaton sequencer.
package ca_pkg;

  localparam int unsigned CA_WIDTH = 32;
  localparam int unsigned CA_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_RUN  = 2'd2
  } ca_state_e;

endpackage

// File: rtl/ca_runner.sv
// Seeds the 32-cell CA array, steps it by a stride and streams selected generations out.
// The array is frozen by reloading its own output whenever this block must not let it advance.
module ca_runner
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH = CA_WIDTH,
  parameter int unsigned CNT_W = CA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] seed_rows,
  input  logic [CNT_W-1:0] seed_stride,
  input  logic             abort,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [WIDTH-1:0] row_data,
  output logic [CNT_W-1:0] row_index,
  output logic             row_last,
  output logic             busy,
  output logic [WIDTH-1:0] ca_state,
  output logic             ca_set_state,
  input  logic [WIDTH-1:0] ca_out
);

  ca_state_e        r_state,     w_state_nx;
  logic [CNT_W-1:0] r_rows_m1,   w_rows_m1_nx;
  logic [CNT_W-1:0] r_stride_m1, w_stride_m1_nx;
  logic [CNT_W-1:0] r_row_idx,   w_row_idx_nx;
  logic [CNT_W-1:0] r_step_cnt,  w_step_cnt_nx;
  logic             w_is_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rows_m1   <= '0;
      r_stride_m1 <= '0;
      r_row_idx   <= '0;
      r_step_cnt  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_rows_m1   <= w_rows_m1_nx;
      r_stride_m1 <= w_stride_m1_nx;
      r_row_idx   <= w_row_idx_nx;
      r_step_cnt  <= w_step_cnt_nx;
    end
  end

  assign w_is_last = (r_row_idx == r_rows_m1);
  assign row_data  = ca_out;
  assign row_index = r_row_idx;

  always_comb begin
    w_state_nx     = r_state;
    w_rows_m1_nx   = r_rows_m1;
    w_stride_m1_nx = r_stride_m1;
    w_row_idx_nx   = r_row_idx;
    w_step_cnt_nx  = r_step_cnt;
    seed_ready     = 1'b0;
    row_valid      = 1'b0;
    row_last       = 1'b0;
    busy           = 1'b0;
    ca_set_state   = 1'b1;
    ca_state       = ca_out;

    if (!rst) begin
      busy = (r_state != ST_IDLE);
      unique case (r_state)
        ST_IDLE: begin
          seed_ready = 1'b1;
          if (seed_valid) begin
            ca_state       = seed;
            w_rows_m1_nx   = (seed_rows == '0) ? '0 : seed_rows - 1'b1;
            w_stride_m1_nx = (seed_stride == '0) ? '0 : seed_stride - 1'b1;
            w_row_idx_nx   = '0;
            w_state_nx     = ST_EMIT;
          end
        end
        ST_EMIT: begin
          row_valid = 1'b1;
          row_last  = w_is_last;
          if (row_ready) begin
            if (w_is_last) begin
              w_state_nx = ST_IDLE;
            end else begin
              ca_set_state = 1'b0;
              w_row_idx_nx = r_row_idx + 1'b1;
              if (r_stride_m1 != '0) begin
                w_step_cnt_nx = r_stride_m1;
                w_state_nx    = ST_RUN;
              end
            end
          end
          // A row accepted together with abort still counts; the array just stops here.
          if (abort) begin
            ca_set_state = 1'b1;
            w_state_nx   = ST_IDLE;
          end
        end
        ST_RUN: begin
          ca_set_state  = 1'b0;
          w_step_cnt_nx = r_step_cnt - 1'b1;
          if (r_step_cnt == CNT_W'(1)) begin
            w_state_nx = ST_EMIT;
          end
          if (abort) begin
            ca_set_state = 1'b1;
            w_state_nx   = ST_IDLE;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_runner.sv
// Scoreboarded bench for ca_runner driving a rule-90 array model with zero boundaries.
module tb_ca_runner;

  localparam int unsigned W = 32;
  localparam int unsigned C = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic [W-1:0] seed = '0;
  logic [C-1:0] seed_rows = '0;
  logic [C-1:0] seed_stride = '0;
  logic         abort = 1'b0;
  logic         row_valid;
  logic         row_ready = 1'b1;
  logic [W-1:0] row_data;
  logic [C-1:0] row_index;
  logic         row_last;
  logic         busy;
  logic [W-1:0] ca_state;
  logic         ca_set_state;
  logic [W-1:0] ca_out;

  logic [W-1:0] ca_q = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic [C-1:0] idx;
    logic         last;
  } row_t;

  row_t exp_q[$];

  always #5 clk = ~clk;

  ca_runner #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed),
    .seed_rows(seed_rows), .seed_stride(seed_stride), .abort(abort),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_index(row_index), .row_last(row_last), .busy(busy),
    .ca_state(ca_state), .ca_set_state(ca_set_state), .ca_out(ca_out)
  );

  // Rule 90 array: each cell becomes the XOR of its two neighbours, boundaries tied to 0.
  always @(posedge clk) begin
    if (ca_set_state) ca_q <= ca_state;
    else              ca_q <= (ca_q << 1) ^ (ca_q >> 1);
  end
  assign ca_out = ca_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted row is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && row_valid && row_ready) begin
      row_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL row_unexpected: got data=0x%0h idx=%0d last=%0b expected none",
                 row_data, row_index, row_last);
      end else begin
        e = exp_q.pop_front();
        if (row_data !== e.data || row_index !== e.idx || row_last !== e.last) begin
          n_errors++;
          $display("FAIL row: got data=0x%0h idx=%0d last=%0b expected data=0x%0h idx=%0d last=%0b",
                   row_data, row_index, row_last, e.data, e.idx, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input int unsigned i, input logic l);
    row_t r;
    r.data = d;
    r.idx  = C'(i);
    r.last = l;
    exp_q.push_back(r);
  endtask

  task automatic send_seed(input logic [W-1:0] s, input logic [C-1:0] n, input logic [C-1:0] st);
    seed = s; seed_rows = n; seed_stride = st; seed_valid = 1'b1;
    check("seed_ready_idle", 64'(seed_ready), 64'd1);
    step();
    seed_valid = 1'b0;
  endtask

  // Counts busy cycles after a handshake until IDLE, bounded.
  task automatic wait_idle(input string name, input int unsigned exp_cycles);
    int unsigned n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    if (busy) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles expected 0", name, n);
    end else begin
      check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
    end
  endtask

  initial begin
    #1;
    check("rst_seed_ready", 64'(seed_ready), 64'd0);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_freeze", 64'(ca_set_state), 64'd1);
    step(); step();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(seed_ready), 64'd1);

    // Stride 1: consecutive generations
    push(32'h0001_0000, 0, 1'b0);
    push(32'h0002_8000, 1, 1'b0);
    push(32'h0004_4000, 2, 1'b1);
    send_seed(32'h0001_0000, 16'd3, 16'd1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_idle("t1", 3);

    // Stride 2: one RUN cycle between emits
    push(32'h0001_0000, 0, 1'b0);
    push(32'h0004_4000, 1, 1'b0);
    push(32'h0010_1000, 2, 1'b1);
    send_seed(32'h0001_0000, 16'd3, 16'd2);
    wait_idle("t2", 5);

    // Backpressure on row 1
    push(32'h0001_0000, 0, 1'b0);
    push(32'h0002_8000, 1, 1'b0);
    push(32'h0004_4000, 2, 1'b1);
    send_seed(32'h0001_0000, 16'd3, 16'd1);
    step();
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(row_valid), 64'd1);
      check("bp_data", 64'(row_data), 64'h0002_8000);
      check("bp_index", 64'(row_index), 64'd1);
      step();
    end
    row_ready = 1'b1;
    wait_idle("t3", 2);

    // Zero rows/stride: single row equal to seed
    push(32'hA5A5_0F0F, 0, 1'b1);
    send_seed(32'hA5A5_0F0F, 16'd0, 16'd0);
    check("t4_last", 64'(row_last), 64'd1);
    wait_idle("t4", 1);

    // Abort during RUN
    push(32'h0001_0000, 0, 1'b0);
    send_seed(32'h0001_0000, 16'd3, 16'd2);
    step();
    check("ab_in_run_valid", 64'(row_valid), 64'd0);
    check("ab_in_run_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_idle_busy", 64'(busy), 64'd0);
    check("ab_idle_valid", 64'(row_valid), 64'd0);
    push(32'h0000_8001, 0, 1'b1);
    send_seed(32'h0000_8001, 16'd1, 16'd5);
    wait_idle("ab_new", 1);

    // Reset while a row is held in EMIT
    row_ready = 1'b0;
    send_seed(32'h1234_5678, 16'd4, 16'd1);
    check("rs_emit_valid", 64'(row_valid), 64'd1);
    check("rs_emit_data", 64'(row_data), 64'h1234_5678);
    rst = 1'b1;
    #1;
    check("rs_valid", 64'(row_valid), 64'd0);
    check("rs_ready", 64'(seed_ready), 64'd0);
    check("rs_last", 64'(row_last), 64'd0);
    step();
    rst = 1'b0;
    row_ready = 1'b1;
    #1;
    check("rs_after_ready", 64'(seed_ready), 64'd1);
    check("rs_after_busy", 64'(busy), 64'd0);
    step();
    check("rs_after_valid", 64'(row_valid), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
